// File: rtl/ibex_if_id_skid.sv
// Two-entry skid register between the prefetch buffer and ID. fetch_ready_o comes
// from a flop, so ID's ready never reaches the fetch FIFO combinationally.
module ibex_if_id_skid #(
   parameter bit ResetAll = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        flush_i,
   input  logic        fetch_valid_i,
   output logic        fetch_ready_o,
   input  logic [31:0] fetch_rdata_i,
   input  logic [31:0] fetch_addr_i,
   input  logic        fetch_err_i,
   input  logic        fetch_err_plus2_i,
   output logic        id_valid_o,
   input  logic        id_ready_i,
   output logic [31:0] id_instr_o,
   output logic        id_instr_c_o,
   output logic [31:0] id_pc_o,
   output logic        id_err_o,
   output logic        id_err_plus2_o,
   output logic        busy_o,
   output logic        perf_bubble_o
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        c;
      logic        err;
      logic        err_plus2;
   } entry_t;

   // Classify and mask at capture so ID sees clean, aligned data.
   function automatic entry_t capture(input logic [31:0] rdata, input logic [31:0] addr,
                                      input logic err, input logic err_plus2);
      entry_t e;
      e.c         = (rdata[1:0] != 2'b11);
      e.instr     = e.c ? {16'h0000, rdata[15:0]} : rdata;
      e.pc        = {addr[31:1], 1'b0};
      e.err       = err;
      e.err_plus2 = err & err_plus2 & ~e.c;
      return e;
   endfunction

   state_e state_r, state_d_s;
   entry_t main_r, skid_r, main_d_s, skid_d_s, cap_s;
   logic   ready_r, valid_r, bubble_r;
   logic   push_s, pop_s, load_main_s, load_skid_s, move_s;

   assign push_s = fetch_valid_i & ready_r & ~flush_i;
   assign pop_s  = valid_r & id_ready_i & ~flush_i;
   assign cap_s  = capture(fetch_rdata_i, fetch_addr_i, fetch_err_i, fetch_err_plus2_i);

   // Next-state and entry load decisions.
   always_comb begin
      state_d_s   = state_r;
      load_main_s = 1'b0;
      load_skid_s = 1'b0;
      move_s      = 1'b0;
      if (flush_i) begin
         state_d_s = EMPTY;
      end else begin
         case (state_r)
            EMPTY: begin
               if (push_s) begin
                  load_main_s = 1'b1;
                  state_d_s   = ONE;
               end else begin
                  state_d_s = EMPTY;
               end
            end
            ONE: begin
               if (push_s && pop_s) begin
                  load_main_s = 1'b1;
                  state_d_s   = ONE;
               end else if (push_s) begin
                  load_skid_s = 1'b1;
                  state_d_s   = TWO;
               end else if (pop_s) begin
                  state_d_s = EMPTY;
               end else begin
                  state_d_s = ONE;
               end
            end
            TWO: begin
               if (pop_s) begin
                  move_s    = 1'b1;
                  state_d_s = ONE;
               end else begin
                  state_d_s = TWO;
               end
            end
            default: state_d_s = EMPTY;
         endcase
      end
   end

   // Entry data muxes; skid always holds the younger instruction.
   always_comb begin
      main_d_s = main_r;
      skid_d_s = skid_r;
      if (load_main_s) begin
         main_d_s = cap_s;
      end else if (move_s) begin
         main_d_s = skid_r;
      end else begin
         main_d_s = main_r;
      end
      if (load_skid_s) begin
         skid_d_s = cap_s;
      end else begin
         skid_d_s = skid_r;
      end
   end

   // Control state and registered handshake/status outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r  <= EMPTY;
         ready_r  <= 1'b1;
         valid_r  <= 1'b0;
         bubble_r <= 1'b0;
      end else begin
         state_r  <= state_d_s;
         ready_r  <= (state_d_s != TWO);
         valid_r  <= (state_d_s != EMPTY);
         bubble_r <= id_ready_i & ~valid_r & ~flush_i;
      end
   end

   generate
      if (ResetAll) begin : g_data_rst
         // Entry payload with asynchronous clear.
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               main_r <= '0;
               skid_r <= '0;
            end else begin
               main_r <= main_d_s;
               skid_r <= skid_d_s;
            end
         end
      end else begin : g_data_norst
         // Entry payload without reset; validity is tracked by the FSM.
         always_ff @(posedge clk_i) begin
            main_r <= main_d_s;
            skid_r <= skid_d_s;
         end
      end
   endgenerate

   assign fetch_ready_o  = ready_r;
   assign id_valid_o     = valid_r;
   assign busy_o         = valid_r;
   assign perf_bubble_o  = bubble_r;
   assign id_instr_o     = main_r.instr;
   assign id_instr_c_o   = main_r.c;
   assign id_pc_o        = main_r.pc;
   assign id_err_o       = main_r.err;
   assign id_err_plus2_o = main_r.err_plus2;

endmodule

// File: tb/tb_ibex_if_id_skid.sv
// Directed bench for ibex_if_id_skid with hand-computed expectations.
module tb_ibex_if_id_skid;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        flush_i;
   logic        fetch_valid_i;
   logic        fetch_ready_o;
   logic [31:0] fetch_rdata_i;
   logic [31:0] fetch_addr_i;
   logic        fetch_err_i;
   logic        fetch_err_plus2_i;
   logic        id_valid_o;
   logic        id_ready_i;
   logic [31:0] id_instr_o;
   logic        id_instr_c_o;
   logic [31:0] id_pc_o;
   logic        id_err_o;
   logic        id_err_plus2_o;
   logic        busy_o;
   logic        perf_bubble_o;

   int total_cnt = 0;
   int bad_cnt   = 0;

   ibex_if_id_skid #(.ResetAll(1'b1)) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .flush_i          (flush_i),
      .fetch_valid_i    (fetch_valid_i),
      .fetch_ready_o    (fetch_ready_o),
      .fetch_rdata_i    (fetch_rdata_i),
      .fetch_addr_i     (fetch_addr_i),
      .fetch_err_i      (fetch_err_i),
      .fetch_err_plus2_i(fetch_err_plus2_i),
      .id_valid_o       (id_valid_o),
      .id_ready_i       (id_ready_i),
      .id_instr_o       (id_instr_o),
      .id_instr_c_o     (id_instr_c_o),
      .id_pc_o          (id_pc_o),
      .id_err_o         (id_err_o),
      .id_err_plus2_o   (id_err_plus2_o),
      .busy_o           (busy_o),
      .perf_bubble_o    (perf_bubble_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      if (obs !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] rdata, input logic [31:0] addr,
                        input logic err, input logic ep2);
      fetch_valid_i     = v;
      fetch_rdata_i     = rdata;
      fetch_addr_i      = addr;
      fetch_err_i       = err;
      fetch_err_plus2_i = ep2;
   endtask

   initial begin
      rst_ni     = 1'b0;
      flush_i    = 1'b0;
      id_ready_i = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #12;
      check_val("rst_valid", {31'd0, id_valid_o}, 32'd0);
      check_val("rst_ready", {31'd0, fetch_ready_o}, 32'd1);
      check_val("rst_busy", {31'd0, busy_o}, 32'd0);
      check_val("rst_bubble", {31'd0, perf_bubble_o}, 32'd0);
      check_val("rst_instr", id_instr_o, 32'd0);
      step();
      rst_ni = 1'b1;

      // Streaming
      id_ready_i = 1'b1;
      drive(1'b1, 32'h0000_0013, 32'h0000_0080, 1'b0, 1'b0);
      step();
      check_val("s1_valid", {31'd0, id_valid_o}, 32'd1);
      check_val("s1_instr", id_instr_o, 32'h0000_0013);
      check_val("s1_c", {31'd0, id_instr_c_o}, 32'd0);
      check_val("s1_pc", id_pc_o, 32'h0000_0080);
      check_val("s1_ready", {31'd0, fetch_ready_o}, 32'd1);
      drive(1'b1, 32'h0000_4501, 32'h0000_0084, 1'b0, 1'b0);
      step();
      check_val("s2_instr", id_instr_o, 32'h0000_4501);
      check_val("s2_c", {31'd0, id_instr_c_o}, 32'd1);
      check_val("s2_pc", id_pc_o, 32'h0000_0084);
      check_val("s2_ready", {31'd0, fetch_ready_o}, 32'd1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      check_val("s3_valid", {31'd0, id_valid_o}, 32'd0);
      step();
      check_val("s3_bubble", {31'd0, perf_bubble_o}, 32'd1);

      // Back-pressure: A, B fill the skid; C waits
      id_ready_i = 1'b0;
      drive(1'b1, 32'h0000_0033, 32'h0000_0200, 1'b0, 1'b0);
      step();
      check_val("bp_a_instr", id_instr_o, 32'h0000_0033);
      drive(1'b1, 32'h0000_0093, 32'h0000_0204, 1'b0, 1'b0);
      step();
      check_val("bp_ready_lo", {31'd0, fetch_ready_o}, 32'd0);
      check_val("bp_bubble_lo", {31'd0, perf_bubble_o}, 32'd0);
      drive(1'b1, 32'h0000_0113, 32'h0000_0208, 1'b0, 1'b0);
      step();
      check_val("bp_hold_a", id_instr_o, 32'h0000_0033);
      check_val("bp_hold_rdy", {31'd0, fetch_ready_o}, 32'd0);
      id_ready_i = 1'b1;
      step();
      check_val("bp_b_instr", id_instr_o, 32'h0000_0093);
      check_val("bp_b_pc", id_pc_o, 32'h0000_0204);
      check_val("bp_ready_hi", {31'd0, fetch_ready_o}, 32'd1);
      step();
      check_val("bp_c_instr", id_instr_o, 32'h0000_0113);
      check_val("bp_c_pc", id_pc_o, 32'h0000_0208);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      check_val("bp_empty", {31'd0, id_valid_o}, 32'd0);

      // Flush while full, with a beat offered in the flush cycle
      id_ready_i = 1'b0;
      drive(1'b1, 32'h0000_0013, 32'h0000_0300, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h0000_4501, 32'h0000_0304, 1'b0, 1'b0);
      step();
      check_val("fl_busy_pre", {31'd0, busy_o}, 32'd1);
      check_val("fl_rdy_pre", {31'd0, fetch_ready_o}, 32'd0);
      flush_i = 1'b1;
      drive(1'b1, 32'h0000_0213, 32'h0000_0400, 1'b0, 1'b0);
      step();
      check_val("fl_valid", {31'd0, id_valid_o}, 32'd0);
      check_val("fl_busy", {31'd0, busy_o}, 32'd0);
      check_val("fl_ready", {31'd0, fetch_ready_o}, 32'd1);
      flush_i = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      check_val("fl_dropped", {31'd0, id_valid_o}, 32'd0);

      // Error flags and odd PC masking
      id_ready_i = 1'b1;
      drive(1'b1, 32'hFFFF_0003, 32'h0000_0500, 1'b1, 1'b1);
      step();
      check_val("e1_err", {31'd0, id_err_o}, 32'd1);
      check_val("e1_ep2", {31'd0, id_err_plus2_o}, 32'd1);
      check_val("e1_instr", id_instr_o, 32'hFFFF_0003);
      drive(1'b1, 32'h0000_C002, 32'h0000_0504, 1'b1, 1'b1);
      step();
      check_val("e2_c", {31'd0, id_instr_c_o}, 32'd1);
      check_val("e2_err", {31'd0, id_err_o}, 32'd1);
      check_val("e2_ep2", {31'd0, id_err_plus2_o}, 32'd0);
      drive(1'b1, 32'hABCD_8082, 32'h0000_0101, 1'b0, 1'b0);
      step();
      check_val("odd_pc", id_pc_o, 32'h0000_0100);
      check_val("odd_instr", id_instr_o, 32'h0000_8082);
      check_val("odd_c", {31'd0, id_instr_c_o}, 32'd1);
      check_val("odd_err", {31'd0, id_err_o}, 32'd0);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      step();

      // Async reset while full
      id_ready_i = 1'b0;
      drive(1'b1, 32'h0000_0013, 32'h0000_0600, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h0000_0093, 32'h0000_0604, 1'b0, 1'b0);
      step();
      check_val("ar_full", {31'd0, fetch_ready_o}, 32'd0);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #2;
      rst_ni = 1'b0;
      #1;
      check_val("ar_valid", {31'd0, id_valid_o}, 32'd0);
      check_val("ar_ready", {31'd0, fetch_ready_o}, 32'd1);
      check_val("ar_bubble", {31'd0, perf_bubble_o}, 32'd0);
      check_val("ar_busy", {31'd0, busy_o}, 32'd0);
      id_ready_i = 1'b1;
      step();
      #3;
      rst_ni = 1'b1;
      step();
      check_val("ar_bubble_on", {31'd0, perf_bubble_o}, 32'd1);
      check_val("ar_still_empty", {31'd0, id_valid_o}, 32'd0);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
